// File: rtl/fphub_pkg.sv
// Shared HUB floating-point definitions for the sequential multiplier and divider.
// Field widths, operand classification and canonical special encodings.
package fphub_pkg;

    localparam int M    = 23;
    localparam int E    = 8;
    localparam int N    = M + E + 1;
    localparam int W    = M + 2;
    localparam int BIAS = 2**(E-1) - 1;

    typedef enum logic [1:0] {
        NORMAL,
        ZERO,
        INF,
        NAN
    } fp_class_t;

    function automatic fp_class_t fphub_classify(input logic [N-1:0] w);
        logic [E-1:0] ex;
        logic [M-1:0] mt;
        ex = w[N-2 -: E];
        mt = w[M-1:0];
        if (ex == '0)
            return ZERO;
        else if (&ex)
            return (mt == '0) ? INF : NAN;
        else
            return NORMAL;
    endfunction

    function automatic logic [N-1:0] fphub_nan();
        return {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
    endfunction

    function automatic logic [N-1:0] fphub_inf(input logic s);
        return {s, {E{1'b1}}, {M{1'b0}}};
    endfunction

    function automatic logic [N-1:0] fphub_zero(input logic s);
        return {s, {(N-1){1'b0}}};
    endfunction

endpackage

// File: rtl/fphub_mul_special.sv
// Special-operand resolution for the HUB multiplier.
// NaN wins, then 0*inf, then inf, then zero.
module fphub_mul_special
    import fphub_pkg::*;
(
    input  fp_class_t      i_cls_x,
    input  fp_class_t      i_cls_y,
    input  logic           i_sign,
    output logic           o_special,
    output logic [N-1:0]   o_res
);

    logic w_nan;
    logic w_inf;
    logic w_zero;

    assign w_nan  = (i_cls_x == NAN) || (i_cls_y == NAN) ||
                    ((i_cls_x == ZERO) && (i_cls_y == INF)) ||
                    ((i_cls_x == INF) && (i_cls_y == ZERO));
    assign w_inf  = (i_cls_x == INF) || (i_cls_y == INF);
    assign w_zero = (i_cls_x == ZERO) || (i_cls_y == ZERO);

    always_comb begin
        o_special = 1'b1;
        o_res     = fphub_zero(i_sign);
        if (w_nan)
            o_res = fphub_nan();
        else if (w_inf)
            o_res = fphub_inf(i_sign);
        else if (w_zero)
            o_res = fphub_zero(i_sign);
        else
            o_special = 1'b0;
    end

endmodule

// File: rtl/fphub_seq_multiplier.sv
// Radix-2 shift-add HUB floating-point multiplier, one multiplier bit per cycle.
// Result is truncated with the implicit ILSB carried in the operand significands.
module fphub_seq_multiplier
    import fphub_pkg::*;
(
    input  logic           clk,
    input  logic           rst_l,
    input  logic           start,
    input  logic [N-1:0]   x,
    input  logic [N-1:0]   y,
    output logic [N-1:0]   res,
    output logic           finish,
    output logic           busy
);

    localparam int CW   = $clog2(W + 1);
    localparam int EMAX = 2**E - 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_NORM,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;
    logic [2*W-1:0]        r_p;
    logic signed [E+1:0]   r_esum;
    logic                  r_sign;
    logic [CW-1:0]         r_cnt;
    logic [N-1:0]          r_res;
    logic                  r_finish;

    fp_class_t             w_cls_x;
    fp_class_t             w_cls_y;
    logic                  w_sign;
    logic                  w_special;
    logic [N-1:0]          w_special_res;
    logic [E+1:0]          w_esum;
    logic [W:0]            w_sum;
    logic [2*W-1:0]        w_p_next;
    logic [M-1:0]          w_frac;
    logic signed [E+1:0]   w_e;
    logic [N-1:0]          w_norm_res;

    assign w_cls_x = fphub_classify(x);
    assign w_cls_y = fphub_classify(y);
    assign w_sign  = x[N-1] ^ y[N-1];
    assign w_esum  = {2'b00, x[N-2 -: E]} + {2'b00, y[N-2 -: E]}
                   - (E+2)'(BIAS);

    fphub_mul_special u_special (
        .i_cls_x   (w_cls_x),
        .i_cls_y   (w_cls_y),
        .i_sign    (w_sign),
        .o_special (w_special),
        .o_res     (w_special_res)
    );

    // Add into the upper half, then shift {carry, P} right by one.
    assign w_sum    = {1'b0, r_p[2*W-1:W]} + (r_b[0] ? {1'b0, r_a} : '0);
    assign w_p_next = {w_sum, r_p[W-1:1]};

    assign w_frac = r_p[2*W-1] ? r_p[2*W-2 -: M] : r_p[2*W-3 -: M];
    assign w_e    = r_esum + $signed({{(E+1){1'b0}}, r_p[2*W-1]});

    always_comb begin
        w_norm_res = {r_sign, w_e[E-1:0], w_frac};
        if (int'(w_e) >= EMAX)
            w_norm_res = fphub_inf(r_sign);
        else if (int'(w_e) <= 0)
            w_norm_res = fphub_zero(r_sign);
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            r_state  <= S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_esum   <= '0;
            r_sign   <= 1'b0;
            r_cnt    <= '0;
            r_res    <= '0;
            r_finish <= 1'b0;
        end else begin
            r_finish <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_sign <= w_sign;
                        if (w_special) begin
                            r_res    <= w_special_res;
                            r_finish <= 1'b1;
                            r_state  <= S_DONE;
                        end else begin
                            r_a     <= {1'b1, x[M-1:0], 1'b1};
                            r_b     <= {1'b1, y[M-1:0], 1'b1};
                            r_esum  <= w_esum;
                            r_p     <= '0;
                            r_cnt   <= '0;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    r_p   <= w_p_next;
                    r_b   <= r_b >> 1;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(W-1))
                        r_state <= S_NORM;
                end
                S_NORM: begin
                    r_res    <= w_norm_res;
                    r_finish <= 1'b1;
                    r_state  <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res    = r_res;
    assign finish = r_finish;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_fphub_seq_multiplier.sv
// Scoreboard bench for the HUB sequential multiplier.
// Driver queues expected results; a monitor checks every finish pulse.
module tb_fphub_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        start;
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] res;
    logic        finish;
    logic        busy;

    fphub_seq_multiplier dut (
        .clk    (clk),
        .rst_l  (rst_l),
        .start  (start),
        .x      (x),
        .y      (y),
        .res    (res),
        .finish (finish),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        int          lat;
        int          issue;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc   = 0;
    int   tests = 0;
    int   fails = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every finish pulse must match the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_l === 1'b1 && finish === 1'b1) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_finish: got finish with res=%h, required no finish", res);
                end else begin
                    e = sb.pop_front();
                    tests++;
                    if (res !== e.res) begin
                        fails++;
                        $display("FAIL %s res: got %h required %h", e.name, res, e.res);
                    end
                    tests++;
                    if (cyc - e.issue != e.lat) begin
                        fails++;
                        $display("FAIL %s latency: got %0d required %0d", e.name, cyc - e.issue, e.lat);
                    end
                end
            end
        end
    end

    task automatic push_exp(input logic [31:0] r, input int lat, input int iss, input string nm);
        exp_t e;
        e.res   = r;
        e.lat   = lat;
        e.issue = iss;
        e.name  = nm;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input int lat, input string nm);
        @(negedge clk);
        x     = a;
        y     = b;
        start = 1'b1;
        push_exp(r, lat, cyc, nm);
        @(negedge clk);
        start = 1'b0;
        x     = $urandom;
        y     = $urandom;
    endtask

    task automatic drain(input string nm);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: got %0d pending results, required 0", nm, sb.size());
            sb.delete();
        end
    endtask

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    initial begin
        int k;
        rst_l = 1'b1;
        start = 1'b0;
        x     = '0;
        y     = '0;
        #1 rst_l = 1'b0;
        #2;
        check("reset_res", res, 32'h0);
        check("reset_finish", {31'b0, finish}, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_l = 1'b1;

        issue(32'h3F800000, 32'h3F800000, 32'h3F800001, 27, "one_x_one");
        drain("one_x_one");
        issue(32'h40000000, 32'h40000000, 32'h40800001, 27, "two_x_two");
        drain("two_x_two");
        issue(32'h3FC00000, 32'h3FC00000, 32'h40100000, 27, "norm_hi");
        drain("norm_hi");
        issue(32'hBF800000, 32'h3F800000, 32'hBF800001, 27, "sign_xor");
        drain("sign_xor");
        issue(32'h80000000, 32'h40400000, 32'h80000000, 1, "neg_zero");
        drain("neg_zero");
        issue(32'h00000000, 32'h7F800000, 32'h7FC00000, 1, "zero_inf");
        drain("zero_inf");
        issue(32'hFF800000, 32'h40000000, 32'hFF800000, 1, "inf_fin");
        drain("inf_fin");
        issue(32'h7FC00000, 32'h3F800000, 32'h7FC00000, 1, "nan_in");
        drain("nan_in");
        issue(32'h7F800000, 32'hFF800000, 32'hFF800000, 1, "inf_inf");
        drain("inf_inf");
        issue(32'h7F000000, 32'h7F000000, 32'h7F800000, 27, "overflow");
        drain("overflow");
        issue(32'h00800000, 32'h00800000, 32'h00000000, 27, "underflow");
        drain("underflow");

        // Stray starts mid-operation must not queue or disturb the result.
        issue(32'h3F800000, 32'h3F800000, 32'h3F800001, 27, "ignore_start");
        repeat (3) @(negedge clk);
        x     = 32'h40400000;
        y     = 32'h40400000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        x     = 32'h40000000;
        y     = 32'h00000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain("ignore_start");
        repeat (3) @(negedge clk);

        // Start held high: back-to-back operations, one idle cycle between.
        @(negedge clk);
        x     = 32'h40000000;
        y     = 32'h40000000;
        start = 1'b1;
        k     = cyc;
        push_exp(32'h40800001, 27, k, "held_0");
        push_exp(32'h40800001, 27, k + 28, "held_1");
        while (cyc < k + 29) @(negedge clk);
        start = 1'b0;
        drain("held");
        repeat (3) @(negedge clk);

        // Asynchronous abort in the middle of an operation.
        @(negedge clk);
        x     = 32'h40000000;
        y     = 32'h40000000;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        #2 rst_l = 1'b0;
        #1;
        check("abort_res", res, 32'h0);
        check("abort_finish", {31'b0, finish}, 32'h0);
        check("abort_busy", {31'b0, busy}, 32'h0);
        @(negedge clk);
        rst_l = 1'b1;
        repeat (30) @(negedge clk);
        issue(32'h40000000, 32'h40000000, 32'h40800001, 27, "after_abort");
        drain("after_abort");
        repeat (5) @(negedge clk);

        check("queue_empty", sb.size(), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
